// File: rtl/fwd_hazard_tracker.sv
// EX/MM producer-side forwarding tracker: carries dest tags, write enables, load flags
// and the EX result toward the bypass muxes, and raises the ID stall. Optional counter: FWD_STALL_CNT_EN.
module fwd_hazard_tracker #(
    parameter int ADDR_WIDTH = 64,
    parameter int REG_NUM    = 32,
    localparam int RW        = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [RW-1:0]         id_rs1,
    input  logic [RW-1:0]         id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [RW-1:0]         id_rd,
    input  logic                  id_wr_reg_en,
    input  logic                  id_is_load,
    input  logic [ADDR_WIDTH-1:0] ex_pro,
    input  logic                  flush_ex,
    input  logic                  mm_stall,
    output logic [RW-1:0]         ex_rd,
    output logic                  ex_wr_reg_en,
    output logic [RW-1:0]         mm_rd,
    output logic                  mm_wr_reg_en,
    output logic                  mm_is_load,
    output logic [ADDR_WIDTH-1:0] mm_pro,
    output logic                  stall_id,
    output logic [31:0]           stall_count
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          wr_en;
        logic          is_load;
    } slot_t;

    slot_t                 ex_q, mm_q, id_slot;
    logic [ADDR_WIDTH-1:0] mm_pro_q;
    logic                  load_use;
    logic                  rs1_hit, rs2_hit;

    // x0 is never a forwarding source, so its write enable is dropped on capture
    always_comb begin
        id_slot         = '0;
        id_slot.valid   = 1'b1;
        id_slot.rd      = id_rd;
        id_slot.wr_en   = id_wr_reg_en & (id_rd != '0);
        id_slot.is_load = id_is_load;
    end

    assign ex_rd        = ex_q.rd;
    assign ex_wr_reg_en = ex_q.valid & ex_q.wr_en;
    assign mm_rd        = mm_q.rd;
    assign mm_wr_reg_en = mm_q.valid & mm_q.wr_en;
    assign mm_is_load   = mm_q.valid & mm_q.is_load;
    assign mm_pro       = mm_pro_q;

    assign rs1_hit  = id_rs1_used & (id_rs1 == ex_q.rd);
    assign rs2_hit  = id_rs2_used & (id_rs2 == ex_q.rd);
    assign load_use = id_valid & ex_wr_reg_en & ex_q.is_load & (rs1_hit | rs2_hit);
    assign stall_id = (load_use | mm_stall) & ~flush_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mm_q     <= '0;
            mm_pro_q <= '0;
        end else if (mm_stall) begin
            // both slots freeze, but a redirect still has to kill the EX slot
            if (flush_ex)
                ex_q <= '0;
        end else begin
            mm_q     <= ex_q;
            mm_pro_q <= ex_pro;
            if (flush_ex || load_use || !id_valid)
                ex_q <= '0;
            else
                ex_q <= id_slot;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load_use && !mm_stall && !flush_ex && (cnt_q != 32'hFFFF_FFFF))
            cnt_q <= cnt_q + 32'd1;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
Producer side of the operand-forwarding path. Carries destination-register tags, write-enables, load flags and the EX ALU result through the EX and MM pipeline slots, and presents them to each operand bypass mux. Detects load-use hazards and pipeline freezes and drives the ID-stage stall. Sits between ID/EX control and the per-operand bypass muxes.

Parameters:
ADDR_WIDTH, 64, datapath width of forwarded results
REG_NUM, 32, architectural register count; tag width RW = $clog2(REG_NUM)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  RW  ID source register 1
id_rs2  in  RW  ID source register 2
id_rs1_used  in  1  rs1 is actually read
id_rs2_used  in  1  rs2 is actually read
id_rd  in  RW  ID destination register
id_wr_reg_en  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
ex_pro  in  ADDR_WIDTH  ALU result of the instruction currently in EX
flush_ex  in  1  branch redirect; squash ID capture and the EX slot
mm_stall  in  1  memory not ready; freeze EX and MM slots
ex_rd  out  RW  EX slot destination tag
ex_wr_reg_en  out  1  EX slot valid and writes a register
mm_rd  out  RW  MM slot destination tag
mm_wr_reg_en  out  1  MM slot valid and writes a register
mm_is_load  out  1  MM slot is a load
mm_pro  out  ADDR_WIDTH  registered EX result now in MM
stall_id  out  1  hold PC and the ID register this cycle
stall_count  out  32  load-use stall cycle count (optional feature)

Behaviour:
- Two internal slots, EX and MM. Each slot holds {valid, rd, wr_en, is_load}; MM also holds pro.
- On capture, wr_en is forced to 0 when rd == 0. x0 is never forwarded.
- Outputs: ex_wr_reg_en = EX.valid & EX.wr_en. mm_wr_reg_en = MM.valid & MM.wr_en. mm_is_load = MM.valid & MM.is_load. Tags and mm_pro come directly from the slot registers.
- load_use (combinational) = id_valid & ex_wr_reg_en & EX.is_load & ((id_rs1_used & id_rs1 == EX.rd) | (id_rs2_used & id_rs2 == EX.rd)).
- stall_id = (load_use | mm_stall) & ~flush_ex. It is a combinational output.
- Per-clock update, in priority order:
  1. rst: both slots invalid; all fields and all outputs 0; stall_count 0.
  2. mm_stall = 1: MM holds. EX holds, except that flush_ex = 1 invalidates EX (a flush is never lost).
  3. otherwise, MM <= EX, with pro <= ex_pro. EX then loads:
     - a bubble if flush_ex, load_use or ~id_valid;
     - otherwise the ID fields.
- Latency: an instruction accepted at edge N appears on the ex_* outputs after edge N and on the mm_* outputs after edge N+1.
- A load-use stall lasts exactly one cycle if no mm_stall occurs. The bubble moves the load to MM, and mm_is_load = 1 selects the memory-data forward.
- flush_ex together with load_use: the flush wins, stall_id = 0 and EX becomes a bubble.
- rst asserted mid-stall: everything clears at the next edge, and stall_id depends only on the inputs present after reset.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- Defined: stall_count increments by 1 on every non-reset clock edge where load_use & ~mm_stall & ~flush_ex. It saturates at 32'hFFFF_FFFF and clears on rst.
- Undefined: no counter logic is built; stall_count is tied to 0.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, stall_id=0 after release with id_valid=0.
- ALU chain: ID rd=5, wr_en=1, ex_pro=64'hA5 -> next cycle ex_rd=5, ex_wr_reg_en=1; following cycle mm_rd=5, mm_pro=64'hA5, mm_is_load=0.
- Load-use: load rd=7 in EX, ID rs1=7 with rs1_used=1 -> stall_id=1 for exactly 1 cycle, EX bubble (ex_wr_reg_en=0), then mm_rd=7, mm_is_load=1, stall_id=0; stall_count=1 when FWD_STALL_CNT_EN is defined.
- x0 and unused operands: load rd=0 with ID rs1=0 -> no stall, ex_wr_reg_en=0. Load rd=3 with ID rs2=3 and rs2_used=0 -> no stall.
- mm_stall hold: mm_stall=1 for 3 cycles with MM rd=9 -> mm_rd, mm_pro and EX fields unchanged and stall_id=1 throughout; resume on release.
- Flush priority: flush_ex=1 in the same cycle as a load-use hazard and mm_stall=1 -> stall_id=0, EX invalid next cycle, MM unchanged, stall_count not incremented.
